// File: rtl/axi4_sram_responder_if.sv
// Bus bundle for axi4_sram_responder: the five AXI4 channels (AW, W, B, AR, R)
// as seen by a single-outstanding SRAM-backed responder.
//   slave  modport : used by the responder (takes i_* signals, drives o_*)
//   master modport : used by the initiator / testbench (drives i_*, takes o_*)
// Signal names keep the responder's point of view (i_ = into the responder).
interface axi4_sram_responder_if;
  logic        i_aw_valid;
  logic        o_aw_ready;
  logic [47:0] i_aw_addr;
  logic [7:0]  i_aw_len;
  logic [1:0]  i_aw_burst;
  logic [4:0]  i_aw_id;
  logic        i_w_valid;
  logic        o_w_ready;
  logic [63:0] i_w_data;
  logic [7:0]  i_w_strb;
  logic        i_w_last;
  logic        o_b_valid;
  logic        i_b_ready;
  logic [1:0]  o_b_resp;
  logic [4:0]  o_b_id;
  logic        i_ar_valid;
  logic        o_ar_ready;
  logic [47:0] i_ar_addr;
  logic [7:0]  i_ar_len;
  logic [1:0]  i_ar_burst;
  logic [4:0]  i_ar_id;
  logic        o_r_valid;
  logic        i_r_ready;
  logic [63:0] o_r_data;
  logic [1:0]  o_r_resp;
  logic        o_r_last;
  logic [4:0]  o_r_id;

  modport slave (
    input  i_aw_valid, i_aw_addr, i_aw_len, i_aw_burst, i_aw_id,
    input  i_w_valid, i_w_data, i_w_strb, i_w_last,
    input  i_b_ready,
    input  i_ar_valid, i_ar_addr, i_ar_len, i_ar_burst, i_ar_id,
    input  i_r_ready,
    output o_aw_ready, o_w_ready, o_b_valid, o_b_resp, o_b_id,
    output o_ar_ready, o_r_valid, o_r_data, o_r_resp, o_r_last, o_r_id
  );

  modport master (
    output i_aw_valid, i_aw_addr, i_aw_len, i_aw_burst, i_aw_id,
    output i_w_valid, i_w_data, i_w_strb, i_w_last,
    output i_b_ready,
    output i_ar_valid, i_ar_addr, i_ar_len, i_ar_burst, i_ar_id,
    output i_r_ready,
    input  o_aw_ready, o_w_ready, o_b_valid, o_b_resp, o_b_id,
    input  o_ar_ready, o_r_valid, o_r_data, o_r_resp, o_r_last, o_r_id
  );
endinterface

// File: rtl/axi4_sram_responder.sv
// AXI4 responder backed by an internal 64-bit-wide SRAM of 2^(abits-3) words.
// One transaction in flight at a time; INCR (wrapping inside the window) and
// FIXED bursts, byte strobes, SLVERR for addresses outside the window.
// Ports:
//   i_clk  - clock, all logic on the rising edge
//   i_rst  - synchronous active-high reset
//   bus    - axi4_sram_responder_if.slave (AW/W/B/AR/R channels)
module axi4_sram_responder #(
  parameter int          abits     = 12,
  parameter logic [47:0] base_addr = 48'h0
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  axi4_sram_responder_if.slave        bus
);
  localparam int DEPTH = 2 ** (abits - 3);

  typedef enum logic [1:0] {IDLE, READ, WDATA, WRESP} state_t;

  state_t           state_q;
  logic [abits-1:0] addr_q;
  logic [7:0]       len_q;
  logic [7:0]       cnt_q;
  logic [4:0]       id_q;
  logic             fixed_q;
  logic             err_q;
  logic             mism_q;
  logic             prio_q;   // 0: read wins a tie, 1: write wins a tie

  logic             r_valid_q;
  logic [63:0]      r_data_q;
  logic [1:0]       r_resp_q;
  logic             r_last_q;
  logic [4:0]       r_id_q;
  logic             b_valid_q;
  logic [1:0]       b_resp_q;
  logic [4:0]       b_id_q;

  logic [63:0]      mem [DEPTH];

  function automatic logic in_window(input logic [47:0] a);
    return a[47:abits] == base_addr[47:abits];
  endfunction

  logic             idle, both, grant_ar, grant_aw;
  logic             w_fire, r_fire, b_fire, last_beat, mism_d;
  logic [47:0]      acc_addr;
  logic             acc_err;
  logic [abits-1:0] addr_d;

  // Ready is a function of state only, except that a tie hides the loser.
  assign idle            = (state_q == IDLE) && !i_rst;
  assign both            = bus.i_ar_valid && bus.i_aw_valid;
  assign bus.o_ar_ready  = idle && !(both && prio_q);
  assign bus.o_aw_ready  = idle && !(both && !prio_q);
  assign bus.o_w_ready   = (state_q == WDATA) && !i_rst;
  assign grant_ar        = bus.o_ar_ready && bus.i_ar_valid;
  assign grant_aw        = bus.o_aw_ready && bus.i_aw_valid;

  assign w_fire    = bus.o_w_ready && bus.i_w_valid;
  assign r_fire    = r_valid_q && bus.i_r_ready;
  assign b_fire    = b_valid_q && bus.i_b_ready;
  assign last_beat = (cnt_q == len_q);
  assign mism_d    = mism_q || (bus.i_w_last != last_beat);

  assign acc_addr  = grant_ar ? bus.i_ar_addr : bus.i_aw_addr;
  assign acc_err   = !in_window(acc_addr);
  // INCR wraps naturally because only the in-window offset is kept.
  assign addr_d    = fixed_q ? addr_q : addr_q + {{(abits-4){1'b0}}, 4'd8};

  assign bus.o_r_valid = r_valid_q;
  assign bus.o_r_data  = r_data_q;
  assign bus.o_r_resp  = r_resp_q;
  assign bus.o_r_last  = r_last_q;
  assign bus.o_r_id    = r_id_q;
  assign bus.o_b_valid = b_valid_q;
  assign bus.o_b_resp  = b_resp_q;
  assign bus.o_b_id    = b_id_q;

  always_ff @(posedge i_clk) begin
    if (w_fire && !err_q) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.i_w_strb[b]) mem[addr_q[abits-1:3]][8*b +: 8] <= bus.i_w_data[8*b +: 8];
      end
    end
  end

  // Read data is fetched one cycle ahead: on acceptance and on every R
  // handshake the next word is registered, so beats flow without bubbles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
      r_last_q  <= 1'b0;
      r_id_q    <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= '0;
      b_id_q    <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      fixed_q   <= 1'b0;
      err_q     <= 1'b0;
      mism_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_ar || grant_aw) begin
            prio_q  <= ~prio_q;
            addr_q  <= acc_addr[abits-1:0];
            len_q   <= grant_ar ? bus.i_ar_len : bus.i_aw_len;
            fixed_q <= grant_ar ? (bus.i_ar_burst == 2'b00) : (bus.i_aw_burst == 2'b00);
            id_q    <= grant_ar ? bus.i_ar_id : bus.i_aw_id;
            cnt_q   <= '0;
            err_q   <= acc_err;
            mism_q  <= 1'b0;
            if (grant_ar) begin
              state_q   <= READ;
              r_valid_q <= 1'b1;
              r_data_q  <= acc_err ? 64'd0 : mem[acc_addr[abits-1:3]];
              r_resp_q  <= acc_err ? 2'b10 : 2'b00;
              r_last_q  <= (bus.i_ar_len == 8'd0);
              r_id_q    <= bus.i_ar_id;
            end else begin
              state_q <= WDATA;
            end
          end
        end
        READ: begin
          if (r_fire) begin
            if (r_last_q) begin
              state_q   <= IDLE;
              r_valid_q <= 1'b0;
              r_last_q  <= 1'b0;
            end else begin
              cnt_q    <= cnt_q + 8'd1;
              addr_q   <= addr_d;
              r_data_q <= err_q ? 64'd0 : mem[addr_d[abits-1:3]];
              r_last_q <= (8'(cnt_q + 8'd1) == len_q);
            end
          end
        end
        WDATA: begin
          if (w_fire) begin
            mism_q <= mism_d;
            if (last_beat) begin
              state_q   <= WRESP;
              b_valid_q <= 1'b1;
              b_resp_q  <= (err_q || mism_d) ? 2'b10 : 2'b00;
              b_id_q    <= id_q;
            end else begin
              cnt_q  <= cnt_q + 8'd1;
              addr_q <= addr_d;
            end
          end
        end
        WRESP: begin
          if (b_fire) begin
            state_q   <= IDLE;
            b_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_sram_responder.sv
// Self-checking bench for axi4_sram_responder: directed scenarios followed by
// randomized transactions, all checked against a word-array reference model.
module tb_axi4_sram_responder;
  localparam int          AB    = 12;
  localparam logic [47:0] BASE  = 48'h0000_1234_5000;
  localparam int          WORDS = 512;
  localparam logic [47:0] WIN   = 48'd4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi4_sram_responder_if bus ();
  axi4_sram_responder #(.abits(AB), .base_addr(BASE)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] ref_mem [WORDS];
  logic [63:0] wq_data [$];
  logic [7:0]  wq_strb [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit oow(input logic [47:0] a);
    return (a / WIN) != (BASE / WIN);
  endfunction

  // Word touched by beat k: FIXED stays put, otherwise step one word per beat
  // and wrap inside the 4 KiB window.
  function automatic int word_of(input logic [47:0] a, input int k, input logic [1:0] burst);
    int w0;
    w0 = int'((a % WIN) / 48'd8);
    if (burst == 2'b00) return w0;
    return (w0 + k) % WORDS;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_aw_valid = 0; bus.i_aw_addr = '0; bus.i_aw_len = '0; bus.i_aw_burst = '0; bus.i_aw_id = '0;
    bus.i_w_valid = 0; bus.i_w_data = '0; bus.i_w_strb = '0; bus.i_w_last = 0;
    bus.i_b_ready = 0;
    bus.i_ar_valid = 0; bus.i_ar_addr = '0; bus.i_ar_len = '0; bus.i_ar_burst = '0; bus.i_ar_id = '0;
    bus.i_r_ready = 0;
  endtask

  task automatic set_ar(input logic [47:0] a, input logic [7:0] len, input logic [1:0] bu, input logic [4:0] id);
    bus.i_ar_addr = a; bus.i_ar_len = len; bus.i_ar_burst = bu; bus.i_ar_id = id;
  endtask

  task automatic set_aw(input logic [47:0] a, input logic [7:0] len, input logic [1:0] bu, input logic [4:0] id);
    bus.i_aw_addr = a; bus.i_aw_len = len; bus.i_aw_burst = bu; bus.i_aw_id = id;
  endtask

  task automatic addr_phase(input bit wr, input logic [47:0] a, input logic [7:0] len,
                            input logic [1:0] bu, input logic [4:0] id, output bit ok);
    ok = 0;
    if (wr) begin set_aw(a, len, bu, id); bus.i_aw_valid = 1; end
    else    begin set_ar(a, len, bu, id); bus.i_ar_valid = 1; end
    for (int c = 0; c < 10 && !ok; c++) begin
      #1;
      if (wr ? bus.o_aw_ready : bus.o_ar_ready) ok = 1;
      tick();
    end
    bus.i_aw_valid = 0;
    bus.i_ar_valid = 0;
    if (!ok) chk("addr_timeout", 0, 1);
  endtask

  // rmode 0: always ready, 1: ready every other cycle (stall first), 2: random
  task automatic rd_beats(input logic [47:0] a, input logic [7:0] len, input logic [1:0] bu,
                          input logic [4:0] id, input int rmode);
    int k = 0;
    int guard = 0;
    bit rdy;
    bit err = oow(a);
    logic [63:0] exp;
    while (k <= int'(len) && guard < 4 * (int'(len) + 1) + 20) begin
      guard++;
      case (rmode)
        0:       rdy = 1;
        1:       rdy = (guard % 2 == 0);
        default: rdy = ($urandom % 4 != 0);
      endcase
      bus.i_r_ready = rdy;
      #1;
      exp = err ? 64'd0 : ref_mem[word_of(a, k, bu)];
      chk("r_valid", bus.o_r_valid, 1);
      chk("r_data", bus.o_r_data, exp);
      chk("r_last", bus.o_r_last, (k == int'(len)));
      chk("r_resp", bus.o_r_resp, err ? 64'd2 : 64'd0);
      chk("r_id", bus.o_r_id, id);
      if (rdy) k++;
      tick();
    end
    bus.i_r_ready = 0;
    if (k <= int'(len)) chk("r_timeout", 0, 1);
    chk("r_valid_end", bus.o_r_valid, 0);
  endtask

  // wmode 0: w_last on final beat, 1: w_last on beat 0 only, 2: w_last never
  task automatic wr_beats(input logic [47:0] a, input logic [7:0] len, input logic [1:0] bu,
                          input logic [4:0] id, input int wmode, input bit gaps);
    bit err = oow(a);
    bit mism = 0;
    bit last;
    int w;
    int d;
    for (int k = 0; k <= int'(len); k++) begin
      if (gaps && ($urandom % 3 == 0)) begin
        bus.i_w_valid = 0;
        #1;
        chk("w_ready_gap", bus.o_w_ready, 1);
        tick();
      end
      last = (wmode == 0) ? (k == int'(len)) : (wmode == 1) ? (k == 0 && len != 0) : 1'b0;
      if (last != (k == int'(len))) mism = 1;
      bus.i_w_valid = 1; bus.i_w_data = wq_data[k]; bus.i_w_strb = wq_strb[k]; bus.i_w_last = last;
      #1;
      chk("w_ready", bus.o_w_ready, 1);
      tick();
      if (!err) begin
        w = word_of(a, k, bu);
        for (int j = 0; j < 8; j++)
          if (wq_strb[k][j]) ref_mem[w][8*j +: 8] = wq_data[k][8*j +: 8];
      end
    end
    bus.i_w_valid = 0; bus.i_w_last = 0;
    d = $urandom % 3;
    for (int i = 0; i <= d; i++) begin
      bus.i_b_ready = (i == d);
      #1;
      chk("b_valid", bus.o_b_valid, 1);
      chk("b_resp", bus.o_b_resp, (err || mism) ? 64'd2 : 64'd0);
      chk("b_id", bus.o_b_id, id);
      tick();
    end
    bus.i_b_ready = 0;
    chk("b_valid_end", bus.o_b_valid, 0);
    wq_data.delete();
    wq_strb.delete();
  endtask

  task automatic write_txn(input logic [47:0] a, input logic [7:0] len, input logic [1:0] bu,
                           input logic [4:0] id, input int wmode, input bit gaps);
    bit ok;
    addr_phase(1, a, len, bu, id, ok);
    if (ok) wr_beats(a, len, bu, id, wmode, gaps);
    else begin wq_data.delete(); wq_strb.delete(); end
  endtask

  task automatic read_txn(input logic [47:0] a, input logic [7:0] len, input logic [1:0] bu,
                          input logic [4:0] id, input int rmode);
    bit ok;
    addr_phase(0, a, len, bu, id, ok);
    if (ok) rd_beats(a, len, bu, id, rmode);
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      wq_data.push_back({$urandom, $urandom});
      wq_strb.push_back(8'hFF);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [47:0] a;
    logic [7:0]  len;
    logic [1:0]  bu;
    int          wmode;

    idle_inputs();
    rst = 1;
    tick(); tick(); tick();
    chk("rst_ar_ready", bus.o_ar_ready, 0);
    chk("rst_aw_ready", bus.o_aw_ready, 0);
    chk("rst_w_ready", bus.o_w_ready, 0);
    chk("rst_r_valid", bus.o_r_valid, 0);
    chk("rst_b_valid", bus.o_b_valid, 0);
    chk("rst_r_data", bus.o_r_data, 0);
    chk("rst_r_resp", bus.o_r_resp, 0);
    chk("rst_r_last", bus.o_r_last, 0);
    chk("rst_r_id", bus.o_r_id, 0);
    chk("rst_b_resp", bus.o_b_resp, 0);
    chk("rst_b_id", bus.o_b_id, 0);
    rst = 0;
    #1;
    chk("idle_ar_ready", bus.o_ar_ready, 1);
    chk("idle_aw_ready", bus.o_aw_ready, 1);
    tick();

    // Fill the whole SRAM; the first burst wraps past the window top.
    fill_rand(256);
    write_txn(BASE + 48'hC00, 8'd255, 2'b01, 5'd1, 0, 0);
    fill_rand(256);
    write_txn(BASE + 48'h400, 8'd255, 2'b01, 5'd2, 0, 0);
    read_txn(BASE + 48'hFF0, 8'd3, 2'b01, 5'd3, 0);

    // Single write then read
    wq_data.push_back(64'h1122334455667788); wq_strb.push_back(8'hFF);
    write_txn(BASE + 48'h10, 8'd0, 2'b01, 5'd4, 0, 0);
    read_txn(BASE + 48'h10, 8'd0, 2'b01, 5'd5, 0);
    chk("model_single", ref_mem[2], 64'h1122334455667788);

    // Byte strobes
    wq_data.push_back(64'hFFFF_FFFF_FFFF_FFFF); wq_strb.push_back(8'hFF);
    write_txn(BASE + 48'h18, 8'd0, 2'b01, 5'd6, 0, 0);
    wq_data.push_back(64'h0); wq_strb.push_back(8'h0F);
    write_txn(BASE + 48'h18, 8'd0, 2'b01, 5'd7, 0, 0);
    chk("model_strb", ref_mem[3], 64'hFFFFFFFF00000000);
    read_txn(BASE + 48'h18, 8'd0, 2'b01, 5'd8, 0);

    // INCR burst with toggling backpressure
    for (int i = 1; i <= 4; i++) begin wq_data.push_back(64'(i)); wq_strb.push_back(8'hFF); end
    write_txn(BASE + 48'h20, 8'd3, 2'b01, 5'd9, 0, 0);
    read_txn(BASE + 48'h20, 8'd3, 2'b01, 5'd10, 1);

    // FIXED burst: only the last value survives
    wq_data.push_back(64'hA); wq_data.push_back(64'hB); wq_data.push_back(64'hC);
    repeat (3) wq_strb.push_back(8'hFF);
    write_txn(BASE + 48'h40, 8'd2, 2'b00, 5'd11, 0, 0);
    chk("model_fixed", ref_mem[8], 64'hC);
    read_txn(BASE + 48'h40, 8'd0, 2'b00, 5'd12, 0);

    // Out of window: SLVERR, zero data, memory untouched
    read_txn(BASE + WIN, 8'd1, 2'b01, 5'd13, 0);
    fill_rand(1);
    write_txn(BASE + WIN, 8'd0, 2'b01, 5'd14, 0, 0);
    read_txn(BASE, 8'd0, 2'b01, 5'd15, 0);

    // w_last early and missing -> SLVERR, data still written
    fill_rand(3);
    write_txn(BASE + 48'h80, 8'd2, 2'b01, 5'd16, 1, 0);
    fill_rand(2);
    write_txn(BASE + 48'h100, 8'd1, 2'b01, 5'd17, 2, 0);
    read_txn(BASE + 48'h80, 8'd2, 2'b01, 5'd18, 0);
    read_txn(BASE + 48'h100, 8'd1, 2'b01, 5'd19, 0);

    // Arbitration: after reset read wins the first tie, write the second
    rst = 1; tick(); rst = 0;
    set_ar(BASE + 48'h200, 8'd0, 2'b01, 5'd20); set_aw(BASE + 48'h208, 8'd0, 2'b01, 5'd21);
    bus.i_ar_valid = 1; bus.i_aw_valid = 1;
    #1;
    chk("tie1_ar_ready", bus.o_ar_ready, 1);
    chk("tie1_aw_ready", bus.o_aw_ready, 0);
    tick();
    bus.i_ar_valid = 0; bus.i_aw_valid = 0;
    rd_beats(BASE + 48'h200, 8'd0, 2'b01, 5'd20, 0);
    bus.i_ar_valid = 1; bus.i_aw_valid = 1;
    #1;
    chk("tie2_ar_ready", bus.o_ar_ready, 0);
    chk("tie2_aw_ready", bus.o_aw_ready, 1);
    tick();
    bus.i_ar_valid = 0; bus.i_aw_valid = 0;
    fill_rand(1);
    wr_beats(BASE + 48'h208, 8'd0, 2'b01, 5'd21, 0, 0);
    read_txn(BASE + 48'h208, 8'd0, 2'b01, 5'd22, 0);

    // Reset during beat 2 of a len 7 read
    begin
      bit ok;
      addr_phase(0, BASE + 48'h300, 8'd7, 2'b01, 5'd23, ok);
      bus.i_r_ready = 1;
      tick(); tick();
      bus.i_r_ready = 0;
      chk("abort_beat2", bus.o_r_data, ref_mem[96 + 2]);
      rst = 1;
      tick();
      chk("abort_r_valid", bus.o_r_valid, 0);
      chk("abort_r_data", bus.o_r_data, 0);
      rst = 0;
      #1;
      chk("abort_ar_ready", bus.o_ar_ready, 1);
      tick();
      chk("abort_quiet", bus.o_r_valid, 0);
      read_txn(BASE + 48'h318, 8'd0, 2'b01, 5'd24, 0);
    end

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      a   = ($urandom % 8 == 0) ? BASE + WIN * 48'($urandom % 4 + 1) : BASE + 48'($urandom % 4096);
      len = 8'($urandom % 16);
      bu  = 2'($urandom % 4);
      if ($urandom % 2) begin
        wmode = ($urandom % 6 == 0) ? 1 + int'($urandom % 2) : 0;
        for (int i = 0; i <= int'(len); i++) begin
          wq_data.push_back({$urandom, $urandom});
          wq_strb.push_back(8'($urandom));
        end
        write_txn(a, len, bu, 5'($urandom), wmode, 1);
      end else begin
        read_txn(a, len, bu, 5'($urandom), int'($urandom % 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
